// File: rtl/mac_seq_pkg.sv
// Shared state encoding and sizing helpers for the
// matrix-multiply MAC operand sequencer.
package mac_seq_pkg;

  localparam int DEFAULT_DIM = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    DONE
  } seq_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_buffer.sv
// Matrix operand store: one synchronous write port and
// one combinational read port.
module operand_buffer
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = idx_w(DEPTH)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mac_operand_sequencer.sv
// Loads A then B row-major, then walks every C element
// through clear / DIM accumulates / drain for a downstream MAC.
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = DEFAULT_DIM
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_valid,
  input  logic [DATA_WIDTH-1:0]   load_data,
  output logic                    load_ready,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    mac_clear,
  output logic                    mac_enable,
  output logic [DATA_WIDTH-1:0]   mac_operand_1,
  output logic [DATA_WIDTH-1:0]   mac_operand_2,
  output logic                    elem_done,
  output logic [idx_w(DIM)-1:0]   elem_row,
  output logic [idx_w(DIM)-1:0]   elem_col,
  output logic                    done
);

  localparam int NE = DIM * DIM;
  localparam int IW = idx_w(DIM);
  localparam int AW = idx_w(NE);
  localparam int PW = idx_w(2 * NE);

  seq_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic loaded_q, loaded_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;

  logic load_ready_q, load_ready_d;
  logic busy_q, busy_d;
  logic mac_clear_q, mac_clear_d;
  logic mac_enable_q, mac_enable_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic elem_done_q, elem_done_d;
  logic [IW-1:0] row_q, row_d, col_q, col_d;
  logic done_q, done_d;

  logic wr_a, wr_b;
  logic [AW-1:0] waddr, a_raddr, b_raddr;
  logic [DATA_WIDTH-1:0] a_rdata, b_rdata;
  logic last_k, last_j, last_elem;

  operand_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(NE)) u_buf_a (
    .clock(clock), .we(wr_a), .waddr(waddr), .wdata(load_data),
    .raddr(a_raddr), .rdata(a_rdata)
  );

  operand_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(NE)) u_buf_b (
    .clock(clock), .we(wr_b), .waddr(waddr), .wdata(load_data),
    .raddr(b_raddr), .rdata(b_rdata)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    loaded_d  = loaded_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    last_k    = (k_q == IW'(DIM - 1));
    last_j    = (j_q == IW'(DIM - 1));
    last_elem = (i_q == IW'(DIM - 1)) && last_j;
    waddr     = (ptr_q < PW'(NE)) ? AW'(ptr_q)
                                  : AW'(ptr_q - PW'(NE));

    // One pointer spans both matrices; its upper half lands in B.
    if (state_q == IDLE && load_valid && load_ready_q) begin
      wr_a = (ptr_q < PW'(NE));
      wr_b = !wr_a;
      if (ptr_q == PW'(2 * NE - 1)) begin
        ptr_d    = '0;
        loaded_d = 1'b1;
      end else begin
        ptr_d = ptr_q + PW'(1);
      end
    end

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && loaded_q && !abort) begin
            state_d = CLEAR;
            i_d     = '0;
            j_d     = '0;
          end
        end
        CLEAR: begin
          state_d = ACCUM;
          k_d     = '0;
        end
        ACCUM: begin
          if (last_k) state_d = DRAIN;
          else        k_d     = k_q + IW'(1);
        end
        DRAIN: begin
          if (last_elem) begin
            state_d = DONE;
          end else begin
            state_d = CLEAR;
            if (last_j) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + IW'(1);
            end
          end
        end
        DONE: begin
          state_d  = IDLE;
          loaded_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end

    a_raddr = AW'(int'(i_d) * DIM + int'(k_d));
    b_raddr = AW'(int'(k_d) * DIM + int'(j_d));

    // Strobes follow the next state so they line up with it once registered.
    load_ready_d = (state_d == IDLE) && !loaded_d;
    busy_d       = (state_d == CLEAR) || (state_d == ACCUM)
                || (state_d == DRAIN);
    mac_clear_d  = (state_d == CLEAR);
    mac_enable_d = (state_d == ACCUM);
    op1_d        = mac_enable_d ? a_rdata : '0;
    op2_d        = mac_enable_d ? b_rdata : '0;
    elem_done_d  = (state_d == DRAIN);
    row_d        = elem_done_d ? i_d : '0;
    col_d        = elem_done_d ? j_d : '0;
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      loaded_q     <= 1'b0;
      i_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      mac_clear_q  <= 1'b0;
      mac_enable_q <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      elem_done_q  <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      loaded_q     <= loaded_d;
      i_q          <= i_d;
      j_q          <= j_d;
      k_q          <= k_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      mac_clear_q  <= mac_clear_d;
      mac_enable_q <= mac_enable_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      elem_done_q  <= elem_done_d;
      row_q        <= row_d;
      col_q        <= col_d;
      done_q       <= done_d;
    end
  end

  assign load_ready    = load_ready_q;
  assign busy          = busy_q;
  assign mac_clear     = mac_clear_q;
  assign mac_enable    = mac_enable_q;
  assign mac_operand_1 = op1_q;
  assign mac_operand_2 = op2_q;
  assign elem_done     = elem_done_q;
  assign elem_row      = row_q;
  assign elem_col      = col_q;
  assign done          = done_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed scoreboard bench: a DIM=2 and a DIM=4 sequencer,
// each feeding a bench-side MAC model checked per element.
module tb_mac_operand_sequencer;

  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          ld_valid2, load_ready2, start2, abort2, busy2;
  logic [DW-1:0] ld_data2, op1_2, op2_2;
  logic          mac_clear2, mac_enable2, elem_done2, done2;
  logic [0:0]    elem_row2, elem_col2;

  logic          ld_valid4, load_ready4, start4, abort4, busy4;
  logic [DW-1:0] ld_data4, op1_4, op2_4;
  logic          mac_clear4, mac_enable4, elem_done4, done4;
  logic [1:0]    elem_row4, elem_col4;

  mac_operand_sequencer #(.DATA_WIDTH(DW), .DIM(2)) u_dut2 (
    .clock(clock), .reset(reset),
    .load_valid(ld_valid2), .load_data(ld_data2),
    .load_ready(load_ready2), .start(start2), .abort(abort2),
    .busy(busy2), .mac_clear(mac_clear2), .mac_enable(mac_enable2),
    .mac_operand_1(op1_2), .mac_operand_2(op2_2),
    .elem_done(elem_done2), .elem_row(elem_row2),
    .elem_col(elem_col2), .done(done2)
  );

  mac_operand_sequencer #(.DATA_WIDTH(DW), .DIM(4)) u_dut4 (
    .clock(clock), .reset(reset),
    .load_valid(ld_valid4), .load_data(ld_data4),
    .load_ready(load_ready4), .start(start4), .abort(abort4),
    .busy(busy4), .mac_clear(mac_clear4), .mac_enable(mac_enable4),
    .mac_operand_1(op1_4), .mac_operand_2(op2_4),
    .elem_done(elem_done4), .elem_row(elem_row4),
    .elem_col(elem_col4), .done(done4)
  );

  typedef struct {
    int     row;
    int     col;
    longint val;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  exp_t   exp2[$], exp4[$];
  exp_t   e2, e4;
  longint acc2 = 0, acc4 = 0;
  int     pairs_a[$], pairs_b[$];
  int     stamps4[$];
  int     words2[8] = '{1, 2, 3, 4, 5, 6, 7, 8};

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A*B for A=[1,2;3,4], B=[5,6;7,8]
  task automatic push_exp2();
    exp2.push_back('{0, 0, 19});
    exp2.push_back('{0, 1, 22});
    exp2.push_back('{1, 0, 43});
    exp2.push_back('{1, 1, 50});
  endtask

  task automatic load2(input int ncyc, input bit toggle, input int first,
                       output int accepted, output logic rdy_after);
    bit hs;
    hs = 0;
    accepted = 0;
    rdy_after = 1'bx;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      if (hs) rdy_after = load_ready2;
      ld_valid2 = toggle ? (c[0] == 1'b0) : 1'b1;
      ld_data2  = DW'(words2[(first + accepted) % 8]);
      hs = ld_valid2 && load_ready2;
      @(posedge clock);
      if (hs) accepted++;
    end
    @(negedge clock);
    if (hs) rdy_after = load_ready2;
    ld_valid2 = 1'b0;
  endtask

  task automatic pulse_start2();
    @(negedge clock);
    start2 = 1'b1;
    @(posedge clock);
    #1 start2 = 1'b0;
  endtask

  // n counts negedges after the accepting edge; n=1 is cycle T+1
  task automatic wait_done2(input int n0, output int nd);
    nd = -1;
    for (int n = n0; n < 400; n++) begin
      @(negedge clock);
      if (done2) begin
        nd = n;
        break;
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(negedge clock);
    if (mac_clear2) acc2 = 0;
    if (mac_enable2) begin
      acc2 += longint'(op1_2) * longint'(op2_2);
      pairs_a.push_back(int'(op1_2));
      pairs_b.push_back(int'(op2_2));
    end
    if (elem_done2) begin
      if (exp2.size() == 0) begin
        check("elem2_unexpected", 1, 0);
      end else begin
        e2 = exp2.pop_front();
        check("elem2_row", elem_row2, e2.row);
        check("elem2_col", elem_col2, e2.col);
        check("elem2_value", acc2, e2.val);
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (mac_clear4) acc4 = 0;
    if (mac_enable4) acc4 += longint'(op1_4) * longint'(op2_4);
    if (elem_done4) begin
      stamps4.push_back(cyc);
      if (exp4.size() == 0) begin
        check("elem4_unexpected", 1, 0);
      end else begin
        e4 = exp4.pop_front();
        check("elem4_row", elem_row4, e4.row);
        check("elem4_col", elem_col4, e4.col);
        check("elem4_value", acc4, e4.val);
      end
    end
  end

  initial begin
    int   acc, nd, cnt, bad;
    logic rdy;
    ld_valid2 = 0; ld_data2 = 0; start2 = 0; abort2 = 0;
    ld_valid4 = 0; ld_data4 = 0; start4 = 0; abort4 = 0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_load_ready", load_ready2, 0);
    check("rst_busy", busy2, 0);
    check("rst_mac_clear", mac_clear2, 0);
    check("rst_mac_enable", mac_enable2, 0);
    check("rst_elem_done", elem_done2, 0);
    check("rst_done", done2, 0);
    check("rst_load_ready4", load_ready4, 0);
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_release", load_ready2, 1);
    check("idle_busy", busy2, 0);

    // toggling valid: exactly 8 accepted, ready drops after the 8th
    load2(24, 1, 0, acc, rdy);
    check("toggle_accept_cnt", acc, 8);
    check("ready_fall_after_8th", rdy, 0);

    // full DIM=2 run
    pairs_a.delete();
    pairs_b.delete();
    push_exp2();
    pulse_start2();
    @(negedge clock);
    check("first_clear", mac_clear2, 1);
    check("first_busy", busy2, 1);
    check("first_clear_no_enable", mac_enable2, 0);
    check("first_clear_op1", op1_2, 0);
    wait_done2(2, nd);
    check("done_cycle_dim2", nd, 17);
    check("done_busy", busy2, 0);
    check("all_elems_dim2", exp2.size(), 0);
    check("pair_count", pairs_a.size(), 8);
    if (pairs_a.size() >= 2) begin
      check("pair0_a", pairs_a[0], 1);
      check("pair0_b", pairs_b[0], 5);
      check("pair1_a", pairs_a[1], 2);
      check("pair1_b", pairs_b[1], 7);
    end
    @(negedge clock);
    check("done_one_cycle", done2, 0);
    check("reload_needed_ready", load_ready2, 1);

    // abort during ACCUM of element (0,1)
    load2(8, 0, 0, acc, rdy);
    check("reload_cnt", acc, 8);
    push_exp2();
    pulse_start2();
    repeat (6) @(negedge clock);
    check("abort_pre_enable", mac_enable2, 1);
    check("abort_pre_op1", op1_2, 1);
    check("abort_pre_op2", op2_2, 6);
    abort2 = 1'b1;
    @(posedge clock);
    #1 abort2 = 1'b0;
    @(negedge clock);
    check("abort_busy", busy2, 0);
    check("abort_enable", mac_enable2, 0);
    check("abort_clear", mac_clear2, 0);
    check("abort_op1", op1_2, 0);
    check("abort_loaded_kept", load_ready2, 0);
    check("abort_pending_elems", exp2.size(), 3);
    exp2.delete();
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (done2 || busy2) cnt++;
    end
    check("abort_no_done", cnt, 0);
    push_exp2();
    pulse_start2();
    wait_done2(1, nd);
    check("restart_done_cycle", nd, 17);
    check("restart_all_elems", exp2.size(), 0);

    // asynchronous reset mid-ACCUM
    load2(8, 0, 0, acc, rdy);
    push_exp2();
    pulse_start2();
    repeat (3) @(negedge clock);
    check("pre_reset_enable", mac_enable2, 1);
    check("pre_reset_op1", op1_2, 2);
    #1 reset = 1'b0;
    #1;
    check("reset_enable", mac_enable2, 0);
    check("reset_op1", op1_2, 0);
    check("reset_op2", op2_2, 0);
    check("reset_busy", busy2, 0);
    check("reset_ready", load_ready2, 0);
    exp2.delete();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_ready", load_ready2, 1);

    // start ignored until a full reload
    pulse_start2();
    @(negedge clock);
    check("start_unloaded_busy", busy2, 0);
    check("start_unloaded_clear", mac_clear2, 0);
    load2(5, 0, 0, acc, rdy);
    check("partial_cnt", acc, 5);
    pulse_start2();
    repeat (2) @(negedge clock);
    check("partial_start_busy", busy2, 0);
    check("partial_start_clear", mac_clear2, 0);
    check("partial_start_ready", load_ready2, 1);
    load2(3, 0, 5, acc, rdy);
    check("rest_cnt", acc, 3);
    check("rest_ready_fall", rdy, 0);
    push_exp2();
    pulse_start2();
    wait_done2(1, nd);
    check("post_reset_done_cycle", nd, 17);
    check("post_reset_all_elems", exp2.size(), 0);

    // DIM=4, all 0xFF
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 32; c++) begin
      @(negedge clock);
      ld_valid4 = 1'b1;
      ld_data4  = 8'hFF;
      acc = int'(load_ready4);
      @(posedge clock);
      if (acc != 0) cnt++;
    end
    @(negedge clock);
    ld_valid4 = 1'b0;
    check("dim4_load_cnt", cnt, 32);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp4.push_back('{i, j, 64'd260100});
    stamps4.delete();
    @(negedge clock);
    start4 = 1'b1;
    @(posedge clock);
    #1 start4 = 1'b0;
    nd = -1;
    for (int n = 1; n < 400; n++) begin
      @(negedge clock);
      if (done4) begin
        nd = n;
        break;
      end
    end
    check("dim4_done_cycle", nd, 97);
    check("dim4_pulses", stamps4.size(), 16);
    bad = 0;
    for (int p = 1; p < stamps4.size(); p++)
      if (stamps4[p] - stamps4[p-1] != 6) bad++;
    check("dim4_spacing", bad, 0);
    check("dim4_all_elems", exp4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_operand_sequencer.md
MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand word width.
REQ-002 SHALL have parameter DIM, default 4: square matrix dimension, legal range 2..8.
REQ-003 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_valid  in  1  operand word offered.
REQ-006 SHALL have port load_data  in  DATA_WIDTH  operand word.
REQ-007 SHALL have port load_ready  out  1  word accepted when load_valid and load_ready are both high.
REQ-008 SHALL have port start  in  1  begin multiply.
REQ-009 SHALL have port abort  in  1  synchronous cancel.
REQ-010 SHALL have port busy  out  1  sequence in progress.
REQ-011 SHALL have port mac_clear  out  1  clears the downstream MAC accumulator.
REQ-012 SHALL have port mac_enable  out  1  tells the downstream MAC to accumulate this cycle.
REQ-013 SHALL have port mac_operand_1  out  DATA_WIDTH  A element to the MAC.
REQ-014 SHALL have port mac_operand_2  out  DATA_WIDTH  B element to the MAC.
REQ-015 SHALL have port elem_done  out  1  MAC result for elem_row/elem_col is valid this cycle.
REQ-016 SHALL have ports elem_row and elem_col  out  $clog2(DIM) each  output element index.
REQ-017 SHALL have port done  out  1  one-cycle pulse after the last element.

Function
REQ-018 SHALL accept 2*DIM*DIM words in row-major order: first all of A, then all of B, using one write pointer.
REQ-019 SHALL drive load_ready high only in IDLE with loaded=0.
REQ-020 SHALL set the loaded flag when the pointer reaches 2*DIM*DIM, and clear the pointer at the same time.
REQ-021 SHALL use FSM states IDLE, CLEAR, ACCUM, DRAIN, DONE.
REQ-022 SHALL go IDLE->CLEAR when start=1 and loaded=1; start with loaded=0 SHALL be ignored.
REQ-023 SHALL process elements (i,j) row-major; per element:
  - CLEAR: 1 cycle, mac_clear=1, mac_enable=0.
  - ACCUM: DIM cycles, mac_enable=1, operands A[i][k] and B[k][j] for k=0..DIM-1.
  - DRAIN: 1 cycle, elem_done=1, elem_row=i, elem_col=j.
REQ-024 SHALL go DRAIN->CLEAR for the next element, or DRAIN->DONE after element (DIM-1,DIM-1).
REQ-025 SHALL, in DONE, pulse done for 1 cycle, clear loaded, and return to IDLE.
REQ-026 SHALL use this timing, with start accepted at edge T: CLEAR of element e at cycle T+1+e*(DIM+2); done at cycle T+1+DIM*DIM*(DIM+2).
REQ-027 SHALL register mac_clear, mac_enable, both operands, elem_done, elem_row, elem_col and done, so each aligns cycle-exactly with its state.
REQ-028 SHALL hold the operand outputs at 0 whenever mac_enable=0.
REQ-029 SHALL hold busy=1 in CLEAR, ACCUM and DRAIN, and busy=0 in IDLE and DONE.
REQ-030 SHALL, on abort=1 in any non-IDLE state, enter IDLE at the next edge with all strobes 0, no done, and loaded retained.
REQ-031 SHALL ignore abort in IDLE.
REQ-032 SHALL give abort priority when abort and start are both asserted.
REQ-033 SHALL ignore start while busy.

Reset
REQ-034 SHALL, while reset=0, force IDLE, write pointer 0, loaded 0, and all outputs 0 (load_ready becomes 1 after release).
REQ-035 SHALL, on reset mid-sequence, discard buffer contents logically (loaded=0); a full reload SHALL be required.

Structure
REQ-036 SHALL place the state enum, default DIM and index-width function in shared package mac_seq_pkg.
REQ-037 SHALL use sub-module operand_buffer (DIM*DIM x DATA_WIDTH register file, 1 write port, 1 combinational read port), instantiated twice (A, B).

Verification
REQ-038 DIM=2, A=[1,2;3,4], B=[5,6;7,8], start: elem_done at (0,0),(0,1),(1,0),(1,1); operand pairs (1,5),(2,7) for (0,0); downstream MAC results 19,22,43,50; done at T+17.
REQ-039 start with only 5 of 8 words loaded -> no state change, busy=0, load_ready stays 1.
REQ-040 Load with load_valid toggling every other cycle -> exactly 8 words accepted; load_ready falls the cycle after the 8th handshake.
REQ-041 abort during ACCUM of element (0,1) -> IDLE next cycle, mac_enable=0, no done; a new start runs the full sequence with the same data.
REQ-042 reset=0 asserted mid-ACCUM -> all outputs 0 immediately; after release, start is ignored until 8 new words are loaded.
REQ-043 DIM=4, all words 8'hFF -> 16 elem_done pulses spaced 6 cycles apart; done at T+97.
